// File: rtl/clock_time_counter.sv
// 24-hour BCD timekeeper with a 1 Hz prescaler. Setup mode freezes time and lets
// two debounced-by-edge buttons select and bump the HH:MM digits.
module clock_time_counter #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  output logic [3:0] secondsLower,
  output logic [2:0] secondsUpper,
  output logic [3:0] minutesLower,
  output logic [2:0] minutesUpper,
  output logic [3:0] hoursLower,
  output logic [1:0] hoursUpper,
  output logic [1:0] location,
  output logic       tick_1hz
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [3:0]    sl_q, sl_d, ml_q, ml_d, hl_q, hl_d;
  logic [2:0]    su_q, su_d, mu_q, mu_d;
  logic [1:0]    hu_q, hu_d, loc_q, loc_d;
  logic          setup_prev_q, setup_prev_d;
  logic [1:0]    nxt_sync_q, nxt_sync_d, inc_sync_q, inc_sync_d, warm_q, warm_d;
  logic          nxt_prev_q, nxt_prev_d, inc_prev_q, inc_prev_d;
  logic          nxt_arm_q, nxt_arm_d, inc_arm_q, inc_arm_d;
  logic          setup_s, nxt_rise_s, inc_rise_s;

  assign setup_s    = (mode == 2'b00);
  assign nxt_rise_s = nxt_sync_q[1] & ~nxt_prev_q & nxt_arm_q;
  assign inc_rise_s = inc_sync_q[1] & ~inc_prev_q & inc_arm_q;

  // Next-state logic: button edge detection, prescaler, time cascade and setup edits
  always_comb begin
    presc_d      = presc_q;
    tick_d       = 1'b0;
    sl_d         = sl_q;
    su_d         = su_q;
    ml_d         = ml_q;
    mu_d         = mu_q;
    hl_d         = hl_q;
    hu_d         = hu_q;
    loc_d        = loc_q;
    setup_prev_d = setup_s;
    nxt_sync_d   = {nxt_sync_q[0], btn_next};
    inc_sync_d   = {inc_sync_q[0], btn_inc};
    nxt_prev_d   = nxt_sync_q[1];
    inc_prev_d   = inc_sync_q[1];
    warm_d       = {warm_q[0], 1'b1};
    // A button still held when reset releases must be seen low before it can act.
    nxt_arm_d    = nxt_arm_q | (warm_q[1] & ~nxt_sync_q[1]);
    inc_arm_d    = inc_arm_q | (warm_q[1] & ~inc_sync_q[1]);

    if (setup_s) begin
      presc_d = '0;
      if (!setup_prev_q) begin
        sl_d  = 4'd0;
        su_d  = 3'd0;
        loc_d = 2'd0;
      end else begin
        if (inc_rise_s) begin
          case (loc_q)
            2'd0: begin
              if (hu_q == 2'd2) begin
                hu_d = 2'd0;
              end else begin
                hu_d = hu_q + 2'd1;
                if ((hu_q == 2'd1) && (hl_q > 4'd3)) hl_d = 4'd3;
                else                                  hl_d = hl_q;
              end
            end
            2'd1: begin
              if (((hu_q == 2'd2) && (hl_q == 4'd3)) || (hl_q == 4'd9)) hl_d = 4'd0;
              else                                                       hl_d = hl_q + 4'd1;
            end
            2'd2: begin
              if (mu_q == 3'd5) mu_d = 3'd0;
              else              mu_d = mu_q + 3'd1;
            end
            2'd3: begin
              if (ml_q == 4'd9) ml_d = 4'd0;
              else              ml_d = ml_q + 4'd1;
            end
            default: hu_d = hu_q;
          endcase
        end else begin
          hu_d = hu_q;
        end
        if (nxt_rise_s) loc_d = loc_q + 2'd1;
        else            loc_d = loc_q;
      end
    end else begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (sl_q == 4'd9) begin
          sl_d = 4'd0;
          if (su_q == 3'd5) begin
            su_d = 3'd0;
            if (ml_q == 4'd9) begin
              ml_d = 4'd0;
              if (mu_q == 3'd5) begin
                mu_d = 3'd0;
                if ((hu_q == 2'd2) && (hl_q == 4'd3)) begin
                  hu_d = 2'd0;
                  hl_d = 4'd0;
                end else if (hl_q == 4'd9) begin
                  hl_d = 4'd0;
                  hu_d = hu_q + 2'd1;
                end else begin
                  hl_d = hl_q + 4'd1;
                end
              end else begin
                mu_d = mu_q + 3'd1;
              end
            end else begin
              ml_d = ml_q + 4'd1;
            end
          end else begin
            su_d = su_q + 3'd1;
          end
        end else begin
          sl_d = sl_q + 4'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      tick_q       <= 1'b0;
      sl_q         <= 4'd0;
      su_q         <= 3'd0;
      ml_q         <= 4'd0;
      mu_q         <= 3'd0;
      hl_q         <= 4'd0;
      hu_q         <= 2'd0;
      loc_q        <= 2'd0;
      setup_prev_q <= 1'b0;
      nxt_sync_q   <= 2'b00;
      inc_sync_q   <= 2'b00;
      nxt_prev_q   <= 1'b0;
      inc_prev_q   <= 1'b0;
      warm_q       <= 2'b00;
      nxt_arm_q    <= 1'b0;
      inc_arm_q    <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      sl_q         <= sl_d;
      su_q         <= su_d;
      ml_q         <= ml_d;
      mu_q         <= mu_d;
      hl_q         <= hl_d;
      hu_q         <= hu_d;
      loc_q        <= loc_d;
      setup_prev_q <= setup_prev_d;
      nxt_sync_q   <= nxt_sync_d;
      inc_sync_q   <= inc_sync_d;
      nxt_prev_q   <= nxt_prev_d;
      inc_prev_q   <= inc_prev_d;
      warm_q       <= warm_d;
      nxt_arm_q    <= nxt_arm_d;
      inc_arm_q    <= inc_arm_d;
    end
  end

  assign secondsLower = sl_q;
  assign secondsUpper = su_q;
  assign minutesLower = ml_q;
  assign minutesUpper = mu_q;
  assign hoursLower   = hl_q;
  assign hoursUpper   = hu_q;
  assign location     = loc_q;
  assign tick_1hz     = tick_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Scoreboard bench for clock_time_counter: a seconds-of-day reference model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_clock_time_counter;
  localparam int CLK_HZ = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd1;
  logic       btn_next = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] secondsLower, minutesLower, hoursLower;
  logic [2:0] secondsUpper, minutesUpper;
  logic [1:0] hoursUpper, location;
  logic       tick_1hz;

  clock_time_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .secondsLower(secondsLower), .secondsUpper(secondsUpper),
    .minutesLower(minutesLower), .minutesUpper(minutesUpper),
    .hoursLower(hoursLower), .hoursUpper(hoursUpper),
    .location(location), .tick_1hz(tick_1hz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] hu; logic [3:0] hl; logic [2:0] mu; logic [3:0] ml;
    logic [2:0] su; logic [3:0] sl; logic [1:0] loc; logic tick;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp, mon_got;
  int   errors = 0;
  int   checks = 0;

  // Reference model: time as seconds of day, buttons as sample histories since reset.
  int   m_t, m_loc, m_cnt, m_edge;
  bit   m_prev_setup;
  bit   hn[$], hi[$];

  function automatic obs_t dut_obs();
    obs_t o;
    o = '{hu: hoursUpper, hl: hoursLower, mu: minutesUpper, ml: minutesLower,
          su: secondsUpper, sl: secondsLower, loc: location, tick: tick_1hz};
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("%0d%0d:%0d%0d:%0d%0d loc=%0d tick=%0d",
                     o.hu, o.hl, o.mu, o.ml, o.su, o.sl, o.loc, o.tick);
  endfunction

  function automatic obs_t model_obs(bit tick);
    obs_t o;
    int h, mi, s;
    h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
    o.hu = 2'(h / 10); o.hl = 4'(h % 10);
    o.mu = 3'(mi / 10); o.ml = 4'(mi % 10);
    o.su = 3'(s / 10); o.sl = 4'(s % 10);
    o.loc = 2'(m_loc); o.tick = tick;
    return o;
  endfunction

  function automatic void model_reset();
    m_t = 0; m_loc = 0; m_cnt = 0; m_edge = 0; m_prev_setup = 1'b0;
    hn.delete(); hi.delete();
  endfunction

  function automatic void model_inc(int sel);
    int hu, hl, mu, ml, s;
    hu = (m_t / 3600) / 10; hl = (m_t / 3600) % 10;
    mu = ((m_t / 60) % 60) / 10; ml = ((m_t / 60) % 60) % 10; s = m_t % 60;
    case (sel)
      0: begin hu = (hu + 1) % 3; if (hu == 2 && hl > 3) hl = 3; end
      1: hl = (hl + 1) % ((hu == 2) ? 4 : 10);
      2: mu = (mu + 1) % 6;
      default: ml = (ml + 1) % 10;
    endcase
    m_t = (hu * 10 + hl) * 3600 + (mu * 10 + ml) * 60 + s;
  endfunction

  // A press acts two edges after its first high sample, provided the sample before was low.
  function automatic void model_edge(logic [1:0] md, logic bn, logic bi);
    bit rn, ri, tick;
    m_edge++;
    hn.push_back(bn); hi.push_back(bi);
    rn = (m_edge >= 4) && hn[m_edge-3] && !hn[m_edge-4];
    ri = (m_edge >= 4) && hi[m_edge-3] && !hi[m_edge-4];
    tick = 1'b0;
    if (md == 2'd0) begin
      m_cnt = 0;
      if (!m_prev_setup) begin
        m_t = m_t - (m_t % 60);
        m_loc = 0;
      end else begin
        if (ri) model_inc(m_loc);
        if (rn) m_loc = (m_loc + 1) % 4;
      end
    end else begin
      m_cnt++;
      if (m_cnt == CLK_HZ) begin
        m_cnt = 0; tick = 1'b1; m_t = (m_t + 1) % 86400;
      end
    end
    m_prev_setup = (md == 2'd0);
    exp_q.push_back(model_obs(tick));
  endfunction

  // Monitor: one expected entry per clock, compared on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = dut_obs();
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL state @%0t got %s exp %s", $time, fmt(mon_got), fmt(mon_exp));
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] m, input logic n, input logic i);
    mode = m; btn_next = n; btn_inc = i;
    @(posedge clk);
    model_edge(m, n, i);
    #1;
  endtask

  task automatic idle(input int cycles, input logic [1:0] m);
    repeat (cycles) step(m, 1'b0, 1'b0);
  endtask

  task automatic press(input int cnt, input logic n, input logic i);
    repeat (cnt) begin
      step(2'd0, n, i);
      repeat (3) step(2'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", int'(dut_obs()), 0);
    model_reset();
    @(posedge clk);
    exp_q.push_back('0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_time(input string name, input int hh, input int mm, input int ss);
    chk({name, "_hh"}, int'(hoursUpper) * 10 + int'(hoursLower), hh);
    chk({name, "_mm"}, int'(minutesUpper) * 10 + int'(minutesLower), mm);
    chk({name, "_ss"}, int'(secondsUpper) * 10 + int'(secondsLower), ss);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] cur_mode;
    model_reset();
    // First tick lands on the 4th edge after reset release.
    mode = 2'd1;
    do_reset();
    idle(3, 2'd1);
    chk("no_early_tick", int'(tick_1hz), 0);
    step(2'd1, 1'b0, 1'b0);
    chk("first_tick", int'(tick_1hz), 1);
    chk("first_tick_sl", int'(secondsLower), 1);

    // Set 23:59 and roll through midnight.
    idle(3, 2'd0);
    press(2, 1'b0, 1'b1);
    press(1, 1'b1, 1'b0);
    press(3, 1'b0, 1'b1);
    press(1, 1'b1, 1'b0);
    press(5, 1'b0, 1'b1);
    press(1, 1'b1, 1'b0);
    press(9, 1'b0, 1'b1);
    chk_time("set_2359", 23, 59, 0);
    chk("set_2359_loc", int'(location), 3);
    idle(59 * CLK_HZ, 2'd1);
    chk_time("pre_midnight", 23, 59, 59);
    idle(CLK_HZ, 2'd1);
    chk_time("midnight", 0, 0, 0);
    chk("midnight_tick", int'(tick_1hz), 1);

    // 09:59:59 -> 10:00:00
    idle(3, 2'd0);
    press(1, 1'b1, 1'b0);
    press(9, 1'b0, 1'b1);
    press(1, 1'b1, 1'b0);
    press(5, 1'b0, 1'b1);
    press(1, 1'b1, 1'b0);
    press(9, 1'b0, 1'b1);
    idle(60 * CLK_HZ, 2'd1);
    chk_time("hour_carry", 10, 0, 0);

    // 17 -> 23 -> 03 on the hours-upper digit
    idle(3, 2'd0);
    press(1, 1'b1, 1'b0);
    press(7, 1'b0, 1'b1);
    press(3, 1'b1, 1'b0);
    chk_time("set_17", 17, 0, 0);
    press(1, 1'b0, 1'b1);
    chk_time("hu_to_2_clamp", 23, 0, 0);
    press(1, 1'b0, 1'b1);
    chk_time("hu_wrap", 3, 0, 0);

    // Simultaneous next+inc at location 11 with minutesLower 9
    press(2, 1'b1, 1'b0);
    press(2, 1'b0, 1'b1);
    press(1, 1'b1, 1'b0);
    press(9, 1'b0, 1'b1);
    chk_time("pre_both", 3, 29, 0);
    press(1, 1'b1, 1'b1);
    chk_time("both", 3, 20, 0);
    chk("both_loc", int'(location), 0);

    // Reset mid-setup with btn_inc held
    press(2, 1'b1, 1'b0);
    step(2'd0, 1'b0, 1'b1);
    step(2'd0, 1'b0, 1'b1);
    do_reset();
    repeat (6) step(2'd0, 1'b0, 1'b1);
    chk_time("held_after_reset", 0, 0, 0);
    chk("held_after_reset_loc", int'(location), 0);
    idle(2, 2'd0);
    press(1, 1'b0, 1'b1);
    chk("repress_inc", int'(hoursUpper), 1);

    // Button activity in run mode must be ignored
    repeat (4) begin
      step(2'd2, 1'b1, 1'b1);
      idle(3, 2'd3);
    end
    chk("run_ignores_btn_loc", int'(location), 0);

    // Randomised mode and button activity
    cur_mode = 2'd1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) cur_mode = 2'($urandom_range(0, 3));
      step(cur_mode, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    idle(2, 2'd1);
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
